// File: rtl/store_packer_if.sv
// -----------------------------------------------------------------------------
// store_packer_if
// Purpose : bundles the upstream store-request handshake and the downstream
//           memory-write handshake of store_packer into one interface.
// Signals : i_valid/o_ready/i_data/i_addr/i_mode  - upstream store request
//           o_valid/i_ready/o_addr/o_wdata/o_wstrb - memory write request
//           o_misaligned                           - one-cycle fault pulse
// Modports: slave  - used by store_packer (drives o_*)
//           master - used by the environment (drives i_*)
// -----------------------------------------------------------------------------
interface store_packer_if #(
   parameter int NBITS = 32
);
   logic             i_valid;
   logic             o_ready;
   logic [NBITS-1:0] i_data;
   logic [NBITS-1:0] i_addr;
   logic [1:0]       i_mode;
   logic             o_valid;
   logic             i_ready;
   logic [NBITS-1:0] o_addr;
   logic [NBITS-1:0] o_wdata;
   logic [3:0]       o_wstrb;
   logic             o_misaligned;

   modport slave (
      input  i_valid, i_data, i_addr, i_mode, i_ready,
      output o_ready, o_valid, o_addr, o_wdata, o_wstrb, o_misaligned
   );

   modport master (
      output i_valid, i_data, i_addr, i_mode, i_ready,
      input  o_ready, o_valid, o_addr, o_wdata, o_wstrb, o_misaligned
   );
endinterface

// File: rtl/store_packer.sv
// -----------------------------------------------------------------------------
// store_packer
// Purpose : turns byte/halfword/word store requests into lane-replicated,
//           byte-strobed word writes, buffered in a 2-entry FIFO so that the
//           output handshake is fully registered (latency 1, no comb path
//           from inputs to outputs).
// Ports   : i_clk   - clock, all state on rising edge
//           i_reset - asynchronous active-high reset
//           bus     - store_packer_if.slave (request in, memory write out)
// Config  : STORE_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//           requests are accepted but dropped and o_misaligned pulses for one
//           cycle; when undefined they are written using aligned lanes and
//           o_misaligned is tied low.
// -----------------------------------------------------------------------------
module store_packer #(
   parameter int NBITS = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   store_packer_if.slave bus
);
   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_WORD = 2'b10;

   logic [NBITS-1:0] addr_q  [2];
   logic [NBITS-1:0] addr_d  [2];
   logic [NBITS-1:0] wdata_q [2];
   logic [NBITS-1:0] wdata_d [2];
   logic [3:0]       wstrb_q [2];
   logic [3:0]       wstrb_d [2];
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;

   logic             ready;
   logic             accept;
   logic             is_store;
   logic             push;
   logic             pop;
   logic [NBITS-1:0] new_wdata;
   logic [3:0]       new_wstrb;

`ifdef STORE_MISALIGN_TRAP_EN
   logic misaligned;
   logic mis_q, mis_d;
`endif

   // Ready depends only on registered occupancy.
   assign ready = (count_q < 2'd2);

   always_comb begin
      new_wdata = bus.i_data;
      new_wstrb = 4'b1111;
      case (bus.i_mode)
         MODE_BYTE: begin
            new_wdata = {(NBITS/8){bus.i_data[7:0]}};
            new_wstrb = 4'b0001 << bus.i_addr[1:0];
         end
         MODE_HALF: begin
            new_wdata = {(NBITS/16){bus.i_data[15:0]}};
            // Only addr[1] selects the half, so a misaligned halfword
            // lands on its aligned lane pair.
            new_wstrb = bus.i_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            new_wdata = bus.i_data;
            new_wstrb = 4'b1111;
         end
      endcase
   end

   always_comb begin
      accept   = bus.i_valid && ready;
      // Mode 11 is accepted and silently dropped.
      is_store = (bus.i_mode != 2'b11);
`ifdef STORE_MISALIGN_TRAP_EN
      misaligned = ((bus.i_mode == MODE_HALF) && bus.i_addr[0]) ||
                   ((bus.i_mode == MODE_WORD) && (bus.i_addr[1:0] != 2'b00));
      push  = accept && is_store && !misaligned;
      mis_d = accept && is_store && misaligned;
`else
      push  = accept && is_store;
`endif
      pop   = (count_q != 2'd0) && bus.i_ready;

      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      if (push) begin
         addr_d[wr_ptr_q]  = {bus.i_addr[NBITS-1:2], 2'b00};
         wdata_d[wr_ptr_q] = new_wdata;
         wstrb_d[wr_ptr_q] = new_wstrb;
      end
      // 1-bit pointers wrap modulo 2 by construction.
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            wstrb_q[i] <= '0;
         end
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
      end
   end

`ifdef STORE_MISALIGN_TRAP_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end
   assign bus.o_misaligned = mis_q;
`else
   assign bus.o_misaligned = 1'b0;
`endif

   assign bus.o_ready = ready;
   assign bus.o_valid = (count_q != 2'd0);
   assign bus.o_addr  = addr_q[rd_ptr_q];
   assign bus.o_wdata = wdata_q[rd_ptr_q];
   assign bus.o_wstrb = wstrb_q[rd_ptr_q];
endmodule
